// File: rtl/pcileech_sysctl.sv
// System control for PCILeech boards: button debounce, uptime counter, stretched system
// reset, long-press config reload and per-LED display modes with activity stretching.
module pcileech_sysctl #(
    parameter int unsigned NUM_BUTTONS        = 2,
    parameter int unsigned RST_BUTTON         = 1,
    parameter int unsigned NUM_LEDS           = 2,
    parameter int unsigned DEBOUNCE_CYCLES    = 100000,
    parameter int unsigned RST_STRETCH_CYCLES = 64,
    parameter int unsigned RELOAD_HOLD_CYCLES = 500000000,
    parameter int unsigned LED_STRETCH_CYCLES = 5000000,
    parameter int unsigned BLINK_BIT          = 24,
    parameter int unsigned BLINK_WINDOW_BIT   = 27
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_BUTTONS-1:0]  btn_n,
    input  logic [NUM_LEDS-1:0]     led_in,
    input  logic [2*NUM_LEDS-1:0]   led_mode,
    output logic [NUM_BUTTONS-1:0]  btn_press,
    output logic [NUM_BUTTONS-1:0]  btn_rise,
    output logic                    sys_rst,
    output logic [1:0]              sys_state,
    output logic                    cfg_reload,
    output logic [63:0]             tickcount,
    output logic [NUM_LEDS-1:0]     led_n
);

    localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned RLW = $clog2(RELOAD_HOLD_CYCLES + 1);
    localparam int unsigned LSW = $clog2(LED_STRETCH_CYCLES + 1);
    localparam logic [DBW-1:0] DB_LAST     = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RLW-1:0] RL_LAST     = RLW'(RELOAD_HOLD_CYCLES - 1);
    localparam logic [RLW-1:0] RL_MAX      = RLW'(RELOAD_HOLD_CYCLES);
    localparam logic [LSW-1:0] LS_LOAD     = LSW'(LED_STRETCH_CYCLES);
    localparam logic [63:0]    STRETCH_END = 64'(RST_STRETCH_CYCLES);

    typedef enum logic [1:0] {
        ST_RESET   = 2'd0,
        ST_STRETCH = 2'd1,
        ST_RUN     = 2'd2
    } state_e;

    logic [NUM_BUTTONS-1:0] sync1_q, sync1_d, sync2_q, sync2_d, btn_lvl;
    logic [NUM_BUTTONS-1:0] press_q, press_d, rise_q, rise_d;
    logic [DBW-1:0]         db_cnt_q [NUM_BUTTONS];
    logic [DBW-1:0]         db_cnt_d [NUM_BUTTONS];
    logic                   hold;
    logic [63:0]            tick_q, tick_d;
    logic                   sys_rst_q, sys_rst_d;
    logic [RLW-1:0]         rl_cnt_q, rl_cnt_d;
    logic                   cfg_q, cfg_d;
    logic [LSW-1:0]         ls_cnt_q [NUM_LEDS];
    logic [LSW-1:0]         ls_cnt_d [NUM_LEDS];
    logic [NUM_LEDS-1:0]    led_act, led_on, led_n_q, led_n_d;
    logic                   pwb;
    state_e                 state_q, state_d;

    // A level must differ from the accepted state for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        sync1_d = btn_n;
        sync2_d = sync1_q;
        btn_lvl = ~sync2_q;
        press_d = press_q;
        rise_d  = '0;
        for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
            db_cnt_d[i] = '0;
            if (btn_lvl[i] != press_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    press_d[i] = btn_lvl[i];
                    rise_d[i]  = btn_lvl[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        hold      = press_q[RST_BUTTON];
        tick_d    = hold ? '0 : ((&tick_q) ? tick_q : tick_q + 64'd1);
        sys_rst_d = tick_d < STRETCH_END;
        rl_cnt_d  = '0;
        cfg_d     = 1'b0;
        if (hold) begin
            rl_cnt_d = (rl_cnt_q == RL_MAX) ? rl_cnt_q : rl_cnt_q + 1'b1;
            cfg_d    = (rl_cnt_q == RL_LAST);
        end
    end

    always_comb begin
        pwb = tick_q[BLINK_BIT] & (tick_q[63:BLINK_WINDOW_BIT] == '0);
        led_act = '0;
        led_on  = '0;
        for (int unsigned i = 0; i < NUM_LEDS; i++) begin
            ls_cnt_d[i] = led_in[i] ? LS_LOAD
                        : ((ls_cnt_q[i] != '0) ? ls_cnt_q[i] - 1'b1 : '0);
            led_act[i]  = led_in[i] | (ls_cnt_q[i] != '0);
            case (led_mode[2*i +: 2])
                2'd0:    led_on[i] = led_in[i];
                2'd1:    led_on[i] = led_act[i];
                2'd2:    led_on[i] = led_in[i] ^ pwb;
                default: led_on[i] = 1'b0;
            endcase
        end
        led_n_d = ~led_on;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (hold) begin
            state_d = ST_RESET;
        end else begin
            case (state_q)
                ST_RESET:   state_d = ST_STRETCH;
                ST_STRETCH: if (tick_d >= STRETCH_END) state_d = ST_RUN;
                ST_RUN:     state_d = ST_RUN;
                default:    state_d = ST_RESET;
            endcase
        end
    end

    always_comb begin
        sys_state = state_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            press_q   <= '0;
            rise_q    <= '0;
            db_cnt_q  <= '{default: '0};
            tick_q    <= '0;
            sys_rst_q <= 1'b1;
            rl_cnt_q  <= '0;
            cfg_q     <= 1'b0;
            ls_cnt_q  <= '{default: '0};
            led_n_q   <= '1;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            press_q   <= press_d;
            rise_q    <= rise_d;
            db_cnt_q  <= db_cnt_d;
            tick_q    <= tick_d;
            sys_rst_q <= sys_rst_d;
            rl_cnt_q  <= rl_cnt_d;
            cfg_q     <= cfg_d;
            ls_cnt_q  <= ls_cnt_d;
            led_n_q   <= led_n_d;
        end
    end

    assign btn_press  = press_q;
    assign btn_rise   = rise_q;
    assign sys_rst    = sys_rst_q;
    assign cfg_reload = cfg_q;
    assign tickcount  = tick_q;
    assign led_n      = led_n_q;

endmodule

// File: tb/tb_pcileech_sysctl.sv
// Bench for pcileech_sysctl: per-cycle expectations from a behavioural model are queued
// by the stimulus side and compared by a negedge monitor; scenario totals checked after.
module tb_pcileech_sysctl;

    localparam int unsigned D  = 4;
    localparam int unsigned S  = 8;
    localparam int unsigned R  = 20;
    localparam int unsigned L  = 5;
    localparam int unsigned BB = 2;
    localparam int unsigned BW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  btn_n, led_in;
    logic [3:0]  led_mode;
    logic [1:0]  btn_press, btn_rise, sys_state, led_n;
    logic        sys_rst, cfg_reload;
    logic [63:0] tickcount;

    always #5 clk = ~clk;

    pcileech_sysctl #(
        .NUM_BUTTONS(2), .RST_BUTTON(1), .NUM_LEDS(2),
        .DEBOUNCE_CYCLES(D), .RST_STRETCH_CYCLES(S), .RELOAD_HOLD_CYCLES(R),
        .LED_STRETCH_CYCLES(L), .BLINK_BIT(BB), .BLINK_WINDOW_BIT(BW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_n(btn_n), .led_in(led_in), .led_mode(led_mode),
        .btn_press(btn_press), .btn_rise(btn_rise), .sys_rst(sys_rst),
        .sys_state(sys_state), .cfg_reload(cfg_reload), .tickcount(tickcount), .led_n(led_n)
    );

    typedef struct packed {
        logic [1:0]  press;
        logic [1:0]  rise;
        logic        sys_rst;
        logic [1:0]  state;
        logic        cfg;
        logic [63:0] tick;
        logic [1:0]  led_n;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_cmp = 0, n_bad = 0;

    // Reference model state: accepted buttons, uptime, length of current hold,
    // cycles since each LED was last requested, raw button history.
    logic [1:0]      m_press;
    logic [63:0]     m_tick;
    longint unsigned m_hold_len;
    int unsigned     m_age [2];
    logic [1:0]      m_hist[$];

    int unsigned ncyc = 0, cfg_seen = 0, rise0_seen = 0, led0_on = 0;
    int unsigned p1_cyc = 0, cfg_cyc = 0;
    logic        prev_p1 = 1'b0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endfunction

    function automatic void model_step();
        exp_t e;
        logic hold, pwb, act, on;
        int unsigned age, idx;
        logic [1:0] h;
        logic stable;
        if (!rst_n) begin
            m_press    = '0;
            m_tick     = '0;
            m_hold_len = 0;
            m_age[0]   = 1000;
            m_age[1]   = 1000;
            m_hist.push_back(2'b11);
            e = '{press: 2'b00, rise: 2'b00, sys_rst: 1'b1, state: 2'd0, cfg: 1'b0,
                  tick: 64'd0, led_n: 2'b11};
        end else begin
            hold       = m_press[1];
            e.tick     = hold ? 64'd0 : ((m_tick == '1) ? m_tick : m_tick + 64'd1);
            e.sys_rst  = (e.tick < S);
            e.state    = (e.tick == 0) ? 2'd0 : ((e.tick < S) ? 2'd1 : 2'd2);
            m_hold_len = hold ? m_hold_len + 1 : 0;
            e.cfg      = hold && (m_hold_len == R);
            pwb = (((m_tick >> BB) % 2) == 1) && (m_tick < (64'd1 << BW));
            for (int i = 0; i < 2; i++) begin
                age = m_age[i] + 1;
                act = led_in[i] || (age <= L);
                m_age[i] = led_in[i] ? 0 : ((age > 1000) ? 1000 : age);
                case (led_mode[2*i +: 2])
                    2'd0:    on = led_in[i];
                    2'd1:    on = act;
                    2'd2:    on = led_in[i] ^ pwb;
                    default: on = 1'b0;
                endcase
                e.led_n[i] = ~on;
            end
            m_hist.push_back(btn_n);
            // A button flips once its synchronised level (raw delayed by 2) has
            // disagreed with the accepted state for the last D cycles.
            for (int b = 0; b < 2; b++) begin
                stable = 1'b1;
                for (int m = 0; m < int'(D); m++) begin
                    idx = m_hist.size() - 1 - (m + 2);
                    h = m_hist[idx];
                    if (~h[b] == m_press[b]) stable = 1'b0;
                end
                e.press[b] = stable ? ~m_press[b] : m_press[b];
                e.rise[b]  = stable & ~m_press[b];
            end
        end
        while (m_hist.size() > 16) void'(m_hist.pop_front());
        m_press = e.press;
        m_tick  = e.tick;
        exp_q.push_back(e);
    endfunction

    task automatic cyc();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_counts();
        #1;
        cfg_seen   = 0;
        rise0_seen = 0;
        led0_on    = 0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            ncyc++;
            check($sformatf("btn_press@%0d", ncyc), 64'(btn_press), 64'(e.press));
            check($sformatf("btn_rise@%0d", ncyc), 64'(btn_rise), 64'(e.rise));
            check($sformatf("sys_rst@%0d", ncyc), 64'(sys_rst), 64'(e.sys_rst));
            check($sformatf("sys_state@%0d", ncyc), 64'(sys_state), 64'(e.state));
            check($sformatf("cfg_reload@%0d", ncyc), 64'(cfg_reload), 64'(e.cfg));
            check($sformatf("tickcount@%0d", ncyc), tickcount, e.tick);
            check($sformatf("led_n@%0d", ncyc), 64'(led_n), 64'(e.led_n));
            if (cfg_reload === 1'b1) begin
                cfg_seen++;
                cfg_cyc = ncyc;
            end
            if (btn_rise[0] === 1'b1) rise0_seen++;
            if (led_n[0] === 1'b0) led0_on++;
            if (btn_press[1] === 1'b1 && prev_p1 !== 1'b1) p1_cyc = ncyc;
            prev_p1 = btn_press[1];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < int'(D) + 4; i++) m_hist.push_back(2'b11);
        m_press = '0; m_tick = '0; m_hold_len = 0; m_age[0] = 1000; m_age[1] = 1000;
        rst_n = 1'b0; btn_n = 2'b11; led_in = 2'b00; led_mode = 4'b0000;
        repeat (3) cyc();
        rst_n = 1'b1;
        repeat (12) cyc();

        clear_counts();
        btn_n[0] = 1'b0; repeat (3) cyc();
        btn_n[0] = 1'b1; repeat (10) cyc();
        #1 check("glitch_rise_count", 64'(rise0_seen), 64'd0);

        clear_counts();
        btn_n[0] = 1'b0; repeat (10) cyc();
        btn_n[0] = 1'b1; repeat (10) cyc();
        #1 check("pulse_rise_count", 64'(rise0_seen), 64'd1);

        clear_counts();
        btn_n[1] = 1'b0; repeat (10) cyc();
        btn_n[1] = 1'b1; repeat (16) cyc();
        #1 check("short_hold_reload_count", 64'(cfg_seen), 64'd0);

        clear_counts();
        btn_n[1] = 1'b0; repeat (30) cyc();
        btn_n[1] = 1'b1; repeat (16) cyc();
        #1 check("long_hold_reload_count", 64'(cfg_seen), 64'd1);
        check("reload_latency", 64'(cfg_cyc - p1_cyc), 64'(R));

        led_mode = 4'b0001;
        clear_counts();
        led_in[0] = 1'b1; cyc();
        led_in[0] = 1'b0; repeat (10) cyc();
        #1 check("led_stretch_len", 64'(led0_on), 64'(L + 1));

        clear_counts();
        led_in[0] = 1'b1; cyc();
        led_in[0] = 1'b0; repeat (2) cyc();
        led_in[0] = 1'b1; cyc();
        led_in[0] = 1'b0; repeat (12) cyc();
        #1 check("led_extend_len", 64'(led0_on), 64'(3 + L + 1));

        rst_n = 1'b0; repeat (3) cyc();
        led_mode = 4'b1010; led_in = 2'b00; rst_n = 1'b1;
        clear_counts();
        repeat (24) cyc();
        #1 check("blink_on_cycles", 64'(led0_on), 64'd8);

        led_mode = 4'b1111;
        clear_counts();
        for (int n = 0; n < 10; n++) begin
            led_in = 2'($urandom);
            cyc();
        end
        #1 check("mode_off_on_cycles", 64'(led0_on), 64'd0);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(99) == 0) begin
                rst_n = 1'b0; repeat (3) cyc(); rst_n = 1'b1;
            end
            if ($urandom_range(5) == 0) btn_n[0] = ~btn_n[0];
            if ($urandom_range(7) == 0) btn_n[1] = ~btn_n[1];
            led_in[0] = ($urandom_range(5) == 0);
            led_in[1] = ($urandom_range(5) == 0);
            if ($urandom_range(19) == 0) led_mode = 4'($urandom);
            cyc();
        end

        #1 check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
